cpu_ctrl_fsm: RTL and testbench



---
 rtl/cpu_ctrl_pkg.sv | 60 ++++++
 rtl/cpu_ctrl_if.sv | 46 ++++
 rtl/cpu_ctrl_fsm_perf_counters.sv | 40 ++++
 rtl/cpu_ctrl_fsm.sv | 165 ++++++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared constants and types for the RV32I multi-cycle controller.
//   - FSM state encoding (plain 3-bit constants)
//   - next-PC source, writeback source and trap cause encodings
//   - RV32I major opcodes, also consumed by the decode unit
//   - small opcode classification helpers
package cpu_ctrl_pkg;

  localparam logic [2:0] ST_FETCH   = 3'd0;
  localparam logic [2:0] ST_DECODE  = 3'd1;
  localparam logic [2:0] ST_EXECUTE = 3'd2;
  localparam logic [2:0] ST_MEM     = 3'd3;
  localparam logic [2:0] ST_WB      = 3'd4;
  localparam logic [2:0] ST_TRAP    = 3'd5;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JAL    = 2'd2,
    PC_JALR   = 2'd3
  } pc_sel_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_ILLEGAL = 2'd1,
    CAUSE_IMEM_TO = 2'd2,
    CAUSE_DMEM_TO = 2'd3
  } trap_cause_e;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Opcodes this sequencer knows how to execute; anything else traps.
  function automatic logic opc_is_legal(input logic [6:0] opc);
    case (opc)
      OPC_R, OPC_I_ALU, OPC_LOAD, OPC_STORE,
      OPC_BRANCH, OPC_JAL, OPC_JALR: opc_is_legal = 1'b1;
      default:                       opc_is_legal = 1'b0;
    endcase
  endfunction

  // Instructions whose ALU second operand is the immediate.
  function automatic logic opc_uses_imm(input logic [6:0] opc);
    case (opc)
      OPC_I_ALU, OPC_LOAD, OPC_STORE, OPC_JALR: opc_uses_imm = 1'b1;
      default:                                  opc_uses_imm = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_ctrl_if.sv
// cpu_ctrl_if: control bundle between the sequencer and the datapath/memories.
//   master modport (sequencer): consumes decode fields, compare result and
//     memory ready flags; drives fetch/memory/regfile/PC strobes, retire
//     pulse, trap status and performance counters.
//   slave modport (datapath side): the mirror image.
interface cpu_ctrl_if
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             branch_taken;
  logic             imem_ready;
  logic             dmem_ready;

  logic             imem_req;
  logic             ir_we;
  logic             dmem_req;
  logic             dmem_we;
  logic             alu_src_b;
  logic             rf_we;
  wb_sel_e          wb_sel;
  logic             pc_we;
  pc_sel_e          pc_sel;
  logic             instr_retired;
  logic             trap;
  trap_cause_e      trap_cause;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] instret_count;

  modport master (
    input  opcode, funct3, branch_taken, imem_ready, dmem_ready,
    output imem_req, ir_we, dmem_req, dmem_we, alu_src_b, rf_we, wb_sel,
           pc_we, pc_sel, instr_retired, trap, trap_cause,
           cycle_count, instret_count
  );

  modport slave (
    output opcode, funct3, branch_taken, imem_ready, dmem_ready,
    input  imem_req, ir_we, dmem_req, dmem_we, alu_src_b, rf_we, wb_sel,
           pc_we, pc_sel, instr_retired, trap, trap_cause,
           cycle_count, instret_count
  );

endinterface

// File: rtl/cpu_ctrl_fsm_perf_counters.sv
// ctrl_perf_counters: free-running cycle and retired-instruction counters.
//   clk, rst      : clock, synchronous active-high reset (clears both)
//   cycle_en      : count this cycle
//   retire_en     : an instruction retires this cycle
//   cycle_count   : cycles counted so far (wraps)
//   instret_count : instructions retired so far (wraps)
module ctrl_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cycle_en,
  input  logic             retire_en,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count
);
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  always_comb begin
    cycle_d   = cycle_q;
    instret_d = instret_q;
    if (cycle_en)  cycle_d   = cycle_q + CNT_W'(1);
    if (retire_en) instret_d = instret_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign cycle_count   = cycle_q;
  assign instret_count = instret_q;

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer for a
// single-issue RV32I core.
//   clk, rst : clock, synchronous active-high reset
//   bus      : cpu_ctrl_if master modport (decode fields and memory ready
//              flags in; IR/PC/regfile/memory strobes, retire pulse, sticky
//              trap + cause and performance counters out)
// Strobes are combinational from state, opcode and ready flags; state, the
// memory wait counter, trap cause and counters are registered.
module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       rst,
  cpu_ctrl_if.master bus
);
  // wait_q counts request cycles that saw no ready; it only needs to reach
  // MEM_TIMEOUT-1, the value on the last cycle before the timeout fires.
  localparam int              WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  logic [2:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  trap_cause_e       cause_q, cause_d;
  logic              is_store;
  logic              unused_funct3;

  assign is_store      = (bus.opcode == OPC_STORE);
  assign unused_funct3 = ^bus.funct3;

  always_comb begin
    state_d           = state_q;
    wait_d            = wait_q;
    cause_d           = cause_q;
    bus.imem_req      = 1'b0;
    bus.ir_we         = 1'b0;
    bus.dmem_req      = 1'b0;
    bus.dmem_we       = 1'b0;
    bus.alu_src_b     = 1'b0;
    bus.rf_we         = 1'b0;
    bus.wb_sel        = WB_ALU;
    bus.pc_we         = 1'b0;
    bus.pc_sel        = PC_PLUS4;
    bus.instr_retired = 1'b0;

    // Strobes stay quiet for the whole reset cycle so an aborted instruction
    // can neither retire nor touch memory.
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          bus.imem_req = 1'b1;
          if (bus.imem_ready) begin
            bus.ir_we = 1'b1;
            state_d   = ST_DECODE;
          end else if (wait_q == WAIT_LAST) begin
            state_d = ST_TRAP;
            cause_d = CAUSE_IMEM_TO;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end

        ST_DECODE: begin
          if (opc_is_legal(bus.opcode)) begin
            state_d = ST_EXECUTE;
          end else begin
            state_d = ST_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        end

        ST_EXECUTE: begin
          bus.alu_src_b = opc_uses_imm(bus.opcode);
          case (bus.opcode)
            OPC_BRANCH: begin
              // Branches resolve here: no writeback, so retire immediately.
              bus.pc_we         = 1'b1;
              bus.instr_retired = 1'b1;
              if (bus.branch_taken) bus.pc_sel = PC_BRANCH;
              state_d = ST_FETCH;
            end
            OPC_LOAD, OPC_STORE: state_d = ST_MEM;
            default:             state_d = ST_WB;
          endcase
        end

        ST_MEM: begin
          bus.dmem_req  = 1'b1;
          bus.dmem_we   = is_store;
          bus.alu_src_b = 1'b1;  // keep the address operand stable
          if (bus.dmem_ready) begin
            if (is_store) begin
              bus.pc_we         = 1'b1;
              bus.instr_retired = 1'b1;
              state_d           = ST_FETCH;
            end else begin
              state_d = ST_WB;
            end
          end else if (wait_q == WAIT_LAST) begin
            state_d = ST_TRAP;
            cause_d = CAUSE_DMEM_TO;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end

        ST_WB: begin
          bus.rf_we         = 1'b1;
          bus.pc_we         = 1'b1;
          bus.instr_retired = 1'b1;
          state_d           = ST_FETCH;
          case (bus.opcode)
            OPC_LOAD: bus.wb_sel = WB_MEM;
            OPC_JAL: begin
              bus.wb_sel = WB_PC4;
              bus.pc_sel = PC_JAL;
            end
            OPC_JALR: begin
              bus.wb_sel = WB_PC4;
              bus.pc_sel = PC_JALR;
            end
            default: ;
          endcase
        end

        ST_TRAP: ;  // absorbing: only reset leaves

        default: state_d = ST_FETCH;  // unused encodings recover to fetch
      endcase
    end

    // Every wait window starts from zero on entry to a new state.
    if (state_d != state_q) wait_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      wait_q  <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
    end
  end

  assign bus.trap       = (state_q == ST_TRAP);
  assign bus.trap_cause = cause_q;

  // Cycle counting stops once trapped; reset clears the counters directly.
  ctrl_perf_counters #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk          (clk),
    .rst          (rst),
    .cycle_en     (state_q != ST_TRAP),
    .retire_en    (bus.instr_retired),
    .cycle_count  (bus.cycle_count),
    .instret_count(bus.instret_count)
  );

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb_cpu_ctrl_fsm: table-driven and randomized self-checking bench for
// cpu_ctrl_fsm (MEM_TIMEOUT=4, CNT_W=4 so timeout and wrap are reachable).
// Each instruction is expanded into a per-cycle schedule of inputs and
// expected strobes from its class and memory latencies; counters are tracked
// as plain integers modulo 2^CNT_W.
module tb_cpu_ctrl_fsm;
  localparam int TB_CNT_W   = 4;
  localparam int TB_TIMEOUT = 4;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BAD  = 7'h7F;

  // Expected-output bit layout:
  // [14]imem_req [13]ir_we [12]dmem_req [11]dmem_we [10]alu_src_b [9]rf_we
  // [8:7]wb_sel [6]pc_we [5:4]pc_sel [3]instr_retired [2]trap [1:0]trap_cause
  localparam logic [14:0] B_IMEM   = 15'h4000;
  localparam logic [14:0] B_IRWE   = 15'h2000;
  localparam logic [14:0] B_DREQ   = 15'h1000;
  localparam logic [14:0] B_DWE    = 15'h0800;
  localparam logic [14:0] B_ASRC   = 15'h0400;
  localparam logic [14:0] B_RFWE   = 15'h0200;
  localparam logic [14:0] WBF_MEM  = 15'h0080;
  localparam logic [14:0] WBF_PC4  = 15'h0100;
  localparam logic [14:0] B_PCWE   = 15'h0040;
  localparam logic [14:0] PCF_BR   = 15'h0010;
  localparam logic [14:0] PCF_JAL  = 15'h0020;
  localparam logic [14:0] PCF_JALR = 15'h0030;
  localparam logic [14:0] B_RET    = 15'h0008;
  localparam logic [14:0] B_TRAP   = 15'h0004;
  localparam logic [14:0] NONE     = 15'h0000;

  typedef struct packed {
    logic [6:0]  opc;
    logic        bt;
    logic        ir;
    logic        dr;
    logic [14:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_ctrl_if #(.CNT_W(TB_CNT_W)) bus ();

  cpu_ctrl_fsm #(
    .MEM_TIMEOUT(TB_TIMEOUT),
    .CNT_W      (TB_CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  logic [14:0] dout;
  assign dout = {bus.imem_req, bus.ir_we, bus.dmem_req, bus.dmem_we, bus.alu_src_b,
                 bus.rf_we, bus.wb_sel, bus.pc_we, bus.pc_sel, bus.instr_retired,
                 bus.trap, bus.trap_cause};

  int   n_checks = 0;
  int   n_errors = 0;
  int   m_cyc    = 0;
  int   m_ret    = 0;
  vec_t q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic add(input logic [6:0] op, input logic bt, input logic ir, input logic dr,
                     input logic [14:0] e);
    vec_t v;
    v.opc = op; v.bt = bt; v.ir = ir; v.dr = dr; v.exp = e;
    q.push_back(v);
  endtask

  // Drive one cycle, sample at the falling edge, then advance the model.
  task automatic apply(input vec_t v, input string tag, input int idx);
    logic [14:0] mask;
    bus.opcode       = v.opc;
    bus.funct3       = 3'($urandom_range(0, 7));
    bus.branch_taken = v.bt;
    bus.imem_ready   = v.ir;
    bus.dmem_ready   = v.dr;
    @(negedge clk);
    mask = 15'h7FFF;
    if (!v.exp[9]) mask[8:7] = 2'b00;  // wb_sel only meaningful with rf_we
    if (!v.exp[6]) mask[5:4] = 2'b00;  // pc_sel only meaningful with pc_we
    check($sformatf("%s[%0d] strobes", tag, idx), 32'(dout & mask), 32'(v.exp));
    check($sformatf("%s[%0d] counters", tag, idx),
          32'({bus.cycle_count, bus.instret_count}),
          32'({TB_CNT_W'(m_cyc), TB_CNT_W'(m_ret)}));
    @(posedge clk);
    #1;
    if (!v.exp[2]) m_cyc++;
    if (v.exp[3])  m_ret++;
  endtask

  task automatic run(input string tag);
    int n;
    n = q.size();
    foreach (q[i]) apply(q[i], tag, i);
    q.delete();
    $display("txn %-10s cycles=%0d model_cycles=%0d model_retired=%0d dut_cycle=%0d dut_instret=%0d",
             tag, n, m_cyc, m_ret, bus.cycle_count, bus.instret_count);
  endtask

  task automatic do_reset(input string tag);
    rst              = 1'b1;
    bus.opcode       = OP_ST;
    bus.funct3       = 3'd0;
    bus.branch_taken = 1'b1;
    bus.imem_ready   = 1'b1;
    bus.dmem_ready   = 1'b1;
    @(negedge clk);
    check({tag, " strobes in reset"}, 32'(dout[14:3]), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check({tag, " reset state"}, 32'({dout, bus.cycle_count, bus.instret_count}), 32'd0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    m_cyc = 0;
    m_ret = 0;
  endtask

  // Expand one legal instruction into its cycle schedule; di/dd are the
  // number of request cycles without ready before the ready cycle.
  task automatic gen(input logic [6:0] op, input logic bt, input int di, input int dd);
    logic [14:0] asrc, mreq, wbx;
    for (int k = 0; k < di; k++) add(op, bt, 1'b0, 1'b0, B_IMEM);
    add(op, bt, 1'b1, 1'b0, B_IMEM | B_IRWE);
    add(op, bt, 1'b0, 1'b0, NONE);
    asrc = (op == OP_I || op == OP_LD || op == OP_ST || op == OP_JALR) ? B_ASRC : NONE;
    if (op == OP_BR) begin
      add(op, bt, 1'b0, 1'b0, asrc | B_PCWE | B_RET | (bt ? PCF_BR : NONE));
    end else begin
      add(op, bt, 1'b0, 1'b0, asrc);
      if (op == OP_LD || op == OP_ST) begin
        mreq = B_DREQ | B_ASRC | ((op == OP_ST) ? B_DWE : NONE);
        for (int k = 0; k < dd; k++) add(op, bt, 1'b0, 1'b0, mreq);
        add(op, bt, 1'b0, 1'b1, mreq | ((op == OP_ST) ? (B_PCWE | B_RET) : NONE));
      end
      if (op != OP_ST) begin
        wbx = B_RFWE | B_PCWE | B_RET;
        if (op == OP_LD)   wbx = wbx | WBF_MEM;
        if (op == OP_JAL)  wbx = wbx | WBF_PC4 | PCF_JAL;
        if (op == OP_JALR) wbx = wbx | WBF_PC4 | PCF_JALR;
        add(op, bt, 1'b0, 1'b0, wbx);
      end
    end
  endtask

  logic [6:0] legal_ops [7];

  initial begin
    legal_ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR};
    do_reset("init");

    // Directed table: ADDI, BEQ taken, BEQ not taken, LW with 3 wait cycles.
    add(OP_I,  1'b0, 1'b1, 1'b0, B_IMEM | B_IRWE);
    add(OP_I,  1'b0, 1'b0, 1'b0, NONE);
    add(OP_I,  1'b0, 1'b0, 1'b0, B_ASRC);
    add(OP_I,  1'b0, 1'b0, 1'b0, B_RFWE | B_PCWE | B_RET);
    add(OP_BR, 1'b1, 1'b1, 1'b0, B_IMEM | B_IRWE);
    add(OP_BR, 1'b1, 1'b0, 1'b0, NONE);
    add(OP_BR, 1'b1, 1'b0, 1'b0, B_PCWE | PCF_BR | B_RET);
    add(OP_BR, 1'b0, 1'b1, 1'b0, B_IMEM | B_IRWE);
    add(OP_BR, 1'b0, 1'b0, 1'b0, NONE);
    add(OP_BR, 1'b0, 1'b0, 1'b0, B_PCWE | B_RET);
    add(OP_LD, 1'b0, 1'b1, 1'b0, B_IMEM | B_IRWE);
    add(OP_LD, 1'b0, 1'b0, 1'b0, NONE);
    add(OP_LD, 1'b0, 1'b0, 1'b0, B_ASRC);
    add(OP_LD, 1'b0, 1'b0, 1'b0, B_DREQ | B_ASRC);
    add(OP_LD, 1'b0, 1'b0, 1'b0, B_DREQ | B_ASRC);
    add(OP_LD, 1'b0, 1'b0, 1'b0, B_DREQ | B_ASRC);
    add(OP_LD, 1'b0, 1'b0, 1'b1, B_DREQ | B_ASRC);
    add(OP_LD, 1'b0, 1'b0, 1'b0, B_RFWE | B_PCWE | B_RET | WBF_MEM);
    run("directed");

    // Fetch ready arrives exactly on the limit cycle: no trap.
    add(OP_JAL, 1'b0, 1'b0, 1'b0, B_IMEM);
    add(OP_JAL, 1'b0, 1'b0, 1'b0, B_IMEM);
    add(OP_JAL, 1'b0, 1'b0, 1'b0, B_IMEM);
    add(OP_JAL, 1'b0, 1'b1, 1'b0, B_IMEM | B_IRWE);
    add(OP_JAL, 1'b0, 1'b0, 1'b0, NONE);
    add(OP_JAL, 1'b0, 1'b0, 1'b0, NONE);
    add(OP_JAL, 1'b0, 1'b0, 1'b0, B_RFWE | B_PCWE | B_RET | WBF_PC4 | PCF_JAL);
    run("imem_limit");

    // Illegal opcode: trap after decode, counters frozen for 20 cycles.
    add(OP_BAD, 1'b0, 1'b1, 1'b0, B_IMEM | B_IRWE);
    add(OP_BAD, 1'b0, 1'b0, 1'b0, NONE);
    for (int k = 0; k < 20; k++) add(OP_BAD, 1'b1, 1'b1, 1'b1, B_TRAP | 15'd1);
    run("illegal");
    do_reset("illegal");

    // Instruction fetch timeout.
    for (int k = 0; k < TB_TIMEOUT; k++) add(OP_R, 1'b0, 1'b0, 1'b0, B_IMEM);
    for (int k = 0; k < 3; k++) add(OP_R, 1'b0, 1'b1, 1'b1, B_TRAP | 15'd2);
    run("imem_to");
    do_reset("imem_to");

    // Data memory timeout on a store.
    add(OP_ST, 1'b0, 1'b1, 1'b0, B_IMEM | B_IRWE);
    add(OP_ST, 1'b0, 1'b0, 1'b0, NONE);
    add(OP_ST, 1'b0, 1'b0, 1'b0, B_ASRC);
    for (int k = 0; k < TB_TIMEOUT; k++) add(OP_ST, 1'b0, 1'b0, 1'b0, B_DREQ | B_DWE | B_ASRC);
    for (int k = 0; k < 3; k++) add(OP_ST, 1'b0, 1'b1, 1'b1, B_TRAP | 15'd3);
    run("dmem_to");
    do_reset("dmem_to");

    // 16 retired branches wrap the 4-bit retire counter back to zero.
    for (int k = 0; k < 16; k++) gen(OP_BR, 1'($urandom_range(0, 1)), 0, 0);
    run("wrap");
    check("wrap instret_count", 32'(bus.instret_count), 32'd0);

    // Reset in the middle of a store's memory phase.
    add(OP_ST, 1'b0, 1'b1, 1'b0, B_IMEM | B_IRWE);
    add(OP_ST, 1'b0, 1'b0, 1'b0, NONE);
    add(OP_ST, 1'b0, 1'b0, 1'b0, B_ASRC);
    add(OP_ST, 1'b0, 1'b0, 1'b0, B_DREQ | B_DWE | B_ASRC);
    run("st_abort");
    rst            = 1'b1;
    bus.dmem_ready = 1'b1;
    @(negedge clk);
    check("abort strobes in reset", 32'(dout[14:3]), 32'd0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    m_cyc = 0;
    m_ret = 0;
    gen(OP_I, 1'b0, 0, 0);
    run("post_abort");

    // Randomized legal instruction stream with random memory latencies.
    for (int i = 0; i < 150; i++) begin
      gen(legal_ops[$urandom_range(0, 6)], 1'($urandom_range(0, 1)),
          int'($urandom_range(0, TB_TIMEOUT - 1)), int'($urandom_range(0, TB_TIMEOUT - 1)));
      run($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
